// File: rtl/mem_fifo_pkg.sv
// Shared configuration for the mem_1r1w-backed FIFO: macro geometry and skid entry type.
package mem_fifo_pkg;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned WIDTH  = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 6;

    typedef struct packed {
        logic [WIDTH-1:0] data;
    } skid_entry_t;

endpackage

// File: rtl/mem_1r1w.sv
// Generated 32 x 64 simple dual-port macro model: one write port, one read port, read latency 1.
module mem_1r1w (
    input  logic [4:0]  R0_addr,
    input  logic        R0_en,
    input  logic        R0_clk,
    output logic [63:0] R0_data,
    input  logic [4:0]  W0_addr,
    input  logic        W0_en,
    input  logic        W0_clk,
    input  logic [63:0] W0_data
);

    logic [63:0] r_mem [0:31];

    always_ff @(posedge R0_clk) begin
        if (R0_en) R0_data <= r_mem[R0_addr];
    end

    always_ff @(posedge W0_clk) begin
        if (W0_en) r_mem[W0_addr] <= W0_data;
    end

endmodule

// File: rtl/mem_fifo_skid.sv
// Two-entry registered skid buffer absorbing the macro read latency; head drives the dequeue port.
import mem_fifo_pkg::*;

module mem_fifo_skid (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  skid_entry_t i_push_data,
    input  logic        i_pop,
    output logic        o_valid,
    output skid_entry_t o_head,
    output logic [1:0]  o_cnt_c
);

    skid_entry_t r_head;
    skid_entry_t r_tail;
    logic        r_head_vld;
    logic        r_tail_vld;
    skid_entry_t w_head_next;
    skid_entry_t w_tail_next;
    logic        w_head_vld_next;
    logic        w_tail_vld_next;

    // The producer never pushes into a full buffer, so push with both slots valid needs no case.
    always_comb begin
        w_head_next     = r_head;
        w_tail_next     = r_tail;
        w_head_vld_next = r_head_vld;
        w_tail_vld_next = r_tail_vld;
        if (i_pop && r_head_vld) begin
            if (r_tail_vld) begin
                w_head_next     = r_tail;
                w_tail_next     = i_push ? i_push_data : r_tail;
                w_tail_vld_next = i_push;
            end else begin
                w_head_next     = i_push ? i_push_data : r_head;
                w_head_vld_next = i_push;
            end
        end else if (i_push) begin
            if (!r_head_vld) begin
                w_head_next     = i_push_data;
                w_head_vld_next = 1'b1;
            end else begin
                w_tail_next     = i_push_data;
                w_tail_vld_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else begin
            r_head     <= w_head_next;
            r_tail     <= w_tail_next;
            r_head_vld <= w_head_vld_next;
            r_tail_vld <= w_tail_vld_next;
        end
    end

    assign o_valid = r_head_vld;
    assign o_head  = r_head;
    assign o_cnt_c = 2'(r_head_vld) + 2'(r_tail_vld);

endmodule

// File: rtl/mem_1r1w_fifo.sv
// First-word-fall-through ready/valid FIFO built on one mem_1r1w macro plus a 2-entry output skid buffer.
import mem_fifo_pkg::*;

module mem_1r1w_fifo #(
    parameter int unsigned DEPTH  = mem_fifo_pkg::DEPTH,
    parameter int unsigned WIDTH  = mem_fifo_pkg::WIDTH,
    parameter int unsigned ADDR_W = mem_fifo_pkg::ADDR_W,
    parameter int unsigned CNT_W  = mem_fifo_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [WIDTH-1:0] enq_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic [CNT_W-1:0] count
);

    if (DEPTH != mem_fifo_pkg::DEPTH || WIDTH != mem_fifo_pkg::WIDTH ||
        ADDR_W != mem_fifo_pkg::ADDR_W || CNT_W != mem_fifo_pkg::CNT_W) begin : g_cfg_err
        $error("mem_1r1w_fifo: parameters must match the mem_1r1w macro configuration");
    end

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_mem_count;
    logic [CNT_W-1:0]  r_count;
    logic              r_inflight;
    logic              r_enq_ready;

    logic              w_enq_fire;
    logic              w_deq_fire;
    logic              w_rd_issue;
    logic [1:0]        w_skid_cnt;
    logic [1:0]        w_skid_cnt_next;
    logic [1:0]        w_down;
    logic [CNT_W-1:0]  w_mem_count_next;
    logic              w_deq_valid;
    skid_entry_t       w_head;
    logic [WIDTH-1:0]  w_r0_data;

    logic              w_w0_en;
    logic [ADDR_W-1:0] w_w0_addr;
    logic              w_r0_en;
    logic [ADDR_W-1:0] w_r0_addr;

    assign w_enq_fire = enq_valid & r_enq_ready;
    assign w_deq_fire = w_deq_valid & deq_ready;

    // Downstream occupancy (in-flight read plus skid) is capped at 2; a read may slip in at 2 only when the head leaves.
    assign w_down     = w_skid_cnt + 2'(r_inflight);
    assign w_rd_issue = (r_mem_count != '0) &&
                        ((w_down < 2'd2) || ((w_down == 2'd2) && w_deq_fire));

    assign w_mem_count_next = r_mem_count + CNT_W'(w_enq_fire) - CNT_W'(w_rd_issue);
    assign w_skid_cnt_next  = w_skid_cnt + 2'(r_inflight) - 2'(w_deq_fire);

    assign w_w0_en   = w_enq_fire;
    assign w_w0_addr = r_wr_ptr;
    assign w_r0_en   = w_rd_issue;
    assign w_r0_addr = r_rd_ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_mem_count <= '0;
            r_inflight  <= 1'b0;
            r_enq_ready <= 1'b1;
            r_count     <= '0;
        end else begin
            if (w_enq_fire) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_rd_issue) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_mem_count <= w_mem_count_next;
            r_inflight  <= w_rd_issue;
            r_enq_ready <= (w_mem_count_next != CNT_W'(DEPTH));
            r_count     <= w_mem_count_next + CNT_W'(w_rd_issue) + CNT_W'(w_skid_cnt_next);
        end
    end

    mem_1r1w u_mem (
        .R0_addr (w_r0_addr),
        .R0_en   (w_r0_en),
        .R0_clk  (clock),
        .R0_data (w_r0_data),
        .W0_addr (w_w0_addr),
        .W0_en   (w_w0_en),
        .W0_clk  (clock),
        .W0_data (enq_data)
    );

    mem_fifo_skid u_skid (
        .clk         (clock),
        .rst         (reset),
        .i_push      (r_inflight),
        .i_push_data ('{data: w_r0_data}),
        .i_pop       (w_deq_fire),
        .o_valid     (w_deq_valid),
        .o_head      (w_head),
        .o_cnt_c     (w_skid_cnt)
    );

    assign enq_ready = r_enq_ready;
    assign deq_valid = w_deq_valid;
    assign deq_data  = w_head.data;
    assign count     = r_count;

endmodule

// File: tb/tb_mem_1r1w_fifo.sv
// Scoreboard bench for mem_1r1w_fifo: latency, fill/drain, streaming, random backpressure, mid-stream reset.
module tb_mem_1r1w_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [63:0] enq_data = '0;
    logic        deq_valid;
    logic        deq_ready = 1'b0;
    logic [63:0] deq_data;
    logic [5:0]  count;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_deq    = 0;
    logic [63:0] sb[$];

    mem_1r1w_fifo dut (
        .clock     (clock),
        .reset     (reset),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .deq_valid (deq_valid),
        .deq_ready (deq_ready),
        .deq_data  (deq_data),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Head is compared every valid cycle, which also proves it holds while stalled.
    always @(negedge clock) begin
        if (!reset) begin
            if (deq_valid) begin
                if (sb.size() == 0) check("deq_unexpected", 64'd1, 64'd0);
                else check("deq_data", deq_data, sb[0]);
                if (deq_ready) begin
                    if (sb.size() != 0) void'(sb.pop_front());
                    n_deq++;
                end
            end
            if (enq_valid && enq_ready) sb.push_back(enq_data);
            if (dut.w_w0_en && dut.w_r0_en)
                check("addr_collision", 64'(dut.w_w0_addr == dut.w_r0_addr), 64'd0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int i, acc, sent, recv, gaps, maxc, d0;
        logic fire;

        // reset values
        #2 reset = 1'b1;
        #2;
        check("rst_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_deq_data", deq_data, 64'd0);
        check("rst_count", 64'(count), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // single entry latency
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 64'hDEADBEEF_00000001;
        step();
        enq_valid = 1'b0;
        check("t1_n1_count", 64'(count), 64'd1);
        check("t1_n1_valid", 64'(deq_valid), 64'd0);
        step();
        check("t1_n2_count", 64'(count), 64'd1);
        check("t1_n2_valid", 64'(deq_valid), 64'd0);
        step();
        check("t1_n3_valid", 64'(deq_valid), 64'd1);
        check("t1_n3_data", deq_data, 64'hDEADBEEF_00000001);
        check("t1_n3_count", 64'(count), 64'd1);
        step();
        check("t1_n4_count", 64'(count), 64'd0);
        check("t1_n4_valid", 64'(deq_valid), 64'd0);

        // fill with deq stalled
        deq_ready = 1'b0;
        i = 0;
        acc = 0;
        for (int c = 0; c < 60; c++) begin
            enq_valid = (i <= 40);
            enq_data  = 64'(i);
            fire = enq_valid && enq_ready;
            step();
            if (fire) begin
                i++;
                acc++;
            end
        end
        enq_valid = 1'b0;
        check("fill_accepted", 64'(acc), 64'd34);
        check("fill_enq_ready", 64'(enq_ready), 64'd0);
        check("fill_count", 64'(count), 64'd34);
        d0 = n_deq;
        deq_ready = 1'b1;
        check("drain_ready_low", 64'(enq_ready), 64'd0);
        step();
        check("drain_ready_back", 64'(enq_ready), 64'd1);
        for (int c = 0; c < 100; c++) begin
            if (sb.size() == 0 && !deq_valid) break;
            step();
        end
        check("drain_n", 64'(n_deq - d0), 64'd34);
        check("drain_empty", 64'(sb.size()), 64'd0);

        // streaming
        sent = 0;
        recv = 0;
        gaps = 0;
        maxc = 0;
        deq_ready = 1'b1;
        for (int c = 0; c < 230; c++) begin
            enq_valid = (sent < 200);
            enq_data  = {$urandom, $urandom};
            fire = enq_valid && enq_ready;
            if (deq_valid) recv++;
            else if (recv > 0 && recv < 200) gaps++;
            if (int'(count) > maxc) maxc = int'(count);
            step();
            if (fire) sent++;
        end
        enq_valid = 1'b0;
        check("stream_sent", 64'(sent), 64'd200);
        check("stream_recv", 64'(recv), 64'd200);
        check("stream_gaps", 64'(gaps), 64'd0);
        check("stream_maxcount", 64'(maxc), 64'd3);

        // random backpressure across pointer wrap
        sent = 0;
        d0 = n_deq;
        for (int c = 0; c < 2000; c++) begin
            if (n_deq - d0 >= 100) break;
            enq_valid = (sent < 100) && ($urandom_range(0, 99) < 80);
            enq_data  = {$urandom, 32'(sent)};
            deq_ready = ($urandom_range(0, 99) < 70);
            fire = enq_valid && enq_ready;
            step();
            if (fire) sent++;
        end
        enq_valid = 1'b0;
        deq_ready = 1'b0;
        check("bp_recv", 64'(n_deq - d0), 64'd100);
        check("bp_empty", 64'(sb.size()), 64'd0);

        // reset with entries queued and a read in flight
        step();
        for (int k = 0; k < 10; k++) begin
            enq_valid = 1'b1;
            enq_data  = 64'(100 + k);
            step();
        end
        enq_valid = 1'b0;
        repeat (4) step();
        check("rst_pre_count", 64'(count), 64'd10);
        deq_ready = 1'b1;
        step();
        deq_ready = 1'b0;
        check("rst_pre_inflight", 64'(dut.r_inflight), 64'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_enq_ready", 64'(enq_ready), 64'd1);
        check("rst_mid_deq_valid", 64'(deq_valid), 64'd0);
        check("rst_mid_deq_data", deq_data, 64'd0);
        check("rst_mid_count", 64'(count), 64'd0);
        check("rst_mid_inflight", 64'(dut.r_inflight), 64'd0);
        sb.delete();
        step();
        step();
        reset = 1'b0;
        step();
        deq_ready = 1'b1;
        enq_valid = 1'b1;
        enq_data  = 64'h5;
        step();
        enq_valid = 1'b0;
        check("post_rst_n1_valid", 64'(deq_valid), 64'd0);
        step();
        check("post_rst_n2_valid", 64'(deq_valid), 64'd0);
        step();
        check("post_rst_n3_valid", 64'(deq_valid), 64'd1);
        check("post_rst_n3_data", deq_data, 64'h5);
        step();
        check("post_rst_n4_valid", 64'(deq_valid), 64'd0);
        check("post_rst_n4_count", 64'(count), 64'd0);
        repeat (5) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
